// File: rtl/path_pkg.sv
// Shared definitions for the maze walker path buffer: direction codes and replay FSM states.
package path_pkg;
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [1:0] {
        PB_IDLE   = 2'd0,
        PB_REPLAY = 2'd1,
        PB_DONE   = 2'd2
    } pb_state_t;
endpackage

// File: rtl/path_buffer_ram.sv
// DEPTH x DATA_W move store: one synchronous write port, two combinational read ports, no reset.
// Zero-latency reads, write visible the cycle after; no backpressure.
module path_buffer_ram
    import path_pkg::*;
#(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              cl,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [CNT_W-1:0]  rd_addr_a,
    output logic [DATA_W-1:0] rd_dat_a,
    input  logic [CNT_W-1:0]  rd_addr_b,
    output logic [DATA_W-1:0] rd_dat_b
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Address decode by compare so count-wide addresses need no truncation.
    always_ff @(posedge cl) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == CNT_W'(i))) mem[i] <= wr_dat;
        end
    end

    always_comb begin
        rd_dat_a = '0;
        rd_dat_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_a == CNT_W'(i)) rd_dat_a = mem[i];
            if (rd_addr_b == CNT_W'(i)) rd_dat_b = mem[i];
        end
    end
endmodule

// File: rtl/path_buffer.sv
// Direction-history LIFO for the maze walker with oldest-first non-destructive replay.
// top is combinational; replay_data/valid one cycle after replay_next; illegal ops are dropped and flagged.
module path_buffer
    import path_pkg::*;
#(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              cl,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] top,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    input  logic              replay_start,
    input  logic              replay_next,
    input  logic              replay_stop,
    output logic [DATA_W-1:0] replay_data,
    output logic              replay_valid,
    output logic              replay_done,
    output logic              ovf_err,
    output logic              unf_err,
    output logic              mode_err
);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    pb_state_t         state, state_nxt;
    logic [CNT_W-1:0]  rd_ptr, rd_ptr_nxt, count_nxt, wr_addr, rd_ptr_inc, count_m1;
    logic              wr_en, ovf_set, unf_set, mode_set, rep_fire;
    logic [DATA_W-1:0] top_dat, rep_dat;

    assign empty       = (count == '0);
    assign full        = (count == FULL_CNT);
    assign count_m1    = count - ONE;
    assign rd_ptr_inc  = rd_ptr + ONE;
    assign top         = empty ? '0 : top_dat;
    assign replay_done = (state == PB_DONE);

    path_buffer_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_ram (
        .cl        (cl),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_dat    (din),
        .rd_addr_a (count_m1),
        .rd_dat_a  (top_dat),
        .rd_addr_b (rd_ptr),
        .rd_dat_b  (rep_dat)
    );

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        rd_ptr_nxt = rd_ptr;
        wr_en      = 1'b0;
        wr_addr    = count;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        mode_set   = 1'b0;
        rep_fire   = 1'b0;
        if (clr) begin
            state_nxt  = PB_IDLE;
            count_nxt  = '0;
            rd_ptr_nxt = '0;
        end else begin
            case (state)
                PB_IDLE: begin
                    if (replay_start) begin
                        mode_set   = push | pop;
                        rd_ptr_nxt = '0;
                        state_nxt  = empty ? PB_DONE : PB_REPLAY;
                    end else if (push && pop) begin
                        // Simultaneous push+pop overwrites the top; on empty it is a plain push.
                        wr_en = 1'b1;
                        if (empty) count_nxt = count + ONE;
                        else       wr_addr   = count_m1;
                    end else if (push) begin
                        if (full) ovf_set = 1'b1;
                        else begin
                            wr_en     = 1'b1;
                            count_nxt = count + ONE;
                        end
                    end else if (pop) begin
                        if (empty) unf_set   = 1'b1;
                        else       count_nxt = count_m1;
                    end
                end
                PB_REPLAY: begin
                    mode_set = push | pop;
                    if (replay_stop) begin
                        state_nxt  = PB_IDLE;
                        rd_ptr_nxt = '0;
                    end else if (replay_next) begin
                        rep_fire   = 1'b1;
                        rd_ptr_nxt = rd_ptr_inc;
                        if (rd_ptr_inc == count) state_nxt = PB_DONE;
                    end
                end
                PB_DONE: begin
                    mode_set = push | pop;
                    if (replay_start) begin
                        rd_ptr_nxt = '0;
                        state_nxt  = empty ? PB_DONE : PB_REPLAY;
                    end else if (replay_stop) begin
                        state_nxt  = PB_IDLE;
                        rd_ptr_nxt = '0;
                    end
                end
                default: state_nxt = PB_IDLE;
            endcase
        end
    end

    always_ff @(posedge cl or negedge rst) begin
        if (!rst) begin
            state        <= PB_IDLE;
            count        <= '0;
            rd_ptr       <= '0;
            replay_data  <= '0;
            replay_valid <= 1'b0;
            ovf_err      <= 1'b0;
            unf_err      <= 1'b0;
            mode_err     <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            rd_ptr       <= rd_ptr_nxt;
            replay_valid <= rep_fire;
            if (rep_fire) replay_data <= rep_dat;
            ovf_err      <= !clr && (ovf_err  || ovf_set);
            unf_err      <= !clr && (unf_err  || unf_set);
            mode_err     <= !clr && (mode_err || mode_set);
        end
    end
endmodule

// File: tb/tb_path_buffer.sv
// Self-checking bench for path_buffer at DEPTH=4: directed scenarios plus random traffic
// compared against a queue-based model of the stack/replay rules.
module tb_path_buffer;
    localparam int DATA_W = 2;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              cl = 1'b0;
    logic              rst;
    logic              clr, push, pop, replay_start, replay_next, replay_stop;
    logic [DATA_W-1:0] din, top, replay_data;
    logic [CNT_W-1:0]  count;
    logic              empty, full, replay_valid, replay_done, ovf_err, unf_err, mode_err;

    int vectors = 0;
    int miscompares = 0;

    // reference model
    logic [DATA_W-1:0] stk[$];
    int                m_mode;    // 0 stack, 1 replaying, 2 finished
    int                m_rp;
    bit                m_valid, m_ovf, m_unf, m_merr;
    logic [DATA_W-1:0] m_data;

    always #5 cl = ~cl;

    path_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .cl(cl), .rst(rst), .clr(clr), .push(push), .pop(pop), .din(din),
        .top(top), .count(count), .empty(empty), .full(full),
        .replay_start(replay_start), .replay_next(replay_next), .replay_stop(replay_stop),
        .replay_data(replay_data), .replay_valid(replay_valid), .replay_done(replay_done),
        .ovf_err(ovf_err), .unf_err(unf_err), .mode_err(mode_err)
    );

    task automatic model_reset();
        stk.delete();
        m_mode = 0; m_rp = 0; m_valid = 0; m_ovf = 0; m_unf = 0; m_merr = 0; m_data = '0;
    endtask

    task automatic model_apply(input bit p, input bit po, input logic [DATA_W-1:0] d,
                               input bit c, input bit rs, input bit rn, input bit rsp);
        m_valid = 0;
        if (c) begin
            stk.delete(); m_mode = 0; m_rp = 0; m_ovf = 0; m_unf = 0; m_merr = 0;
            return;
        end
        if (m_mode != 0 && (p || po)) m_merr = 1;
        case (m_mode)
            0: begin
                if (rs) begin
                    if (p || po) m_merr = 1;
                    m_rp = 0;
                    m_mode = (stk.size() > 0) ? 1 : 2;
                end else if (p && po) begin
                    if (stk.size() == 0) stk.push_back(d);
                    else stk[stk.size()-1] = d;
                end else if (p) begin
                    if (stk.size() == DEPTH) m_ovf = 1;
                    else stk.push_back(d);
                end else if (po) begin
                    if (stk.size() == 0) m_unf = 1;
                    else void'(stk.pop_back());
                end
            end
            1: begin
                if (rsp) begin
                    m_mode = 0; m_rp = 0;
                end else if (rn) begin
                    m_valid = 1; m_data = stk[m_rp]; m_rp++;
                    if (m_rp == stk.size()) m_mode = 2;
                end
            end
            default: begin
                if (rs) begin
                    m_rp = 0; m_mode = (stk.size() > 0) ? 1 : 2;
                end else if (rsp) begin
                    m_mode = 0; m_rp = 0;
                end
            end
        endcase
    endtask

    task automatic cyc(input bit p, input bit po, input logic [DATA_W-1:0] d,
                       input bit c, input bit rs, input bit rn, input bit rsp);
        push = p; pop = po; din = d; clr = c;
        replay_start = rs; replay_next = rn; replay_stop = rsp;
        model_apply(p, po, d, c, rs, rn, rsp);
        @(posedge cl); #1;
        push = 0; pop = 0; din = '0; clr = 0;
        replay_start = 0; replay_next = 0; replay_stop = 0;
    endtask

    task automatic test_reset();
        rst = 0; push = 0; pop = 0; din = '0; clr = 0;
        replay_start = 0; replay_next = 0; replay_stop = 0;
        model_reset();
        repeat (2) @(posedge cl);
        #1 rst = 1;
        vectors++; if (count !== 0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
        vectors++; if ({empty, full} !== 2'b10) begin miscompares++; $display("FAIL reset_empty_full got %b want 10", {empty, full}); end
        vectors++; if ({replay_valid, replay_done, replay_data, top} !== 6'b0) begin miscompares++; $display("FAIL reset_replay got %b want 0", {replay_valid, replay_done, replay_data, top}); end
        vectors++; if ({ovf_err, unf_err, mode_err} !== 3'b0) begin miscompares++; $display("FAIL reset_errs got %b want 000", {ovf_err, unf_err, mode_err}); end
    endtask

    task automatic test_push_pop();
        cyc(1, 0, 2'b01, 0, 0, 0, 0);
        cyc(1, 0, 2'b11, 0, 0, 0, 0);
        cyc(1, 0, 2'b10, 0, 0, 0, 0);
        vectors++; if (count !== 3) begin miscompares++; $display("FAIL push3_count got %0d want 3", count); end
        vectors++; if (top !== 2'b10) begin miscompares++; $display("FAIL push3_top got %b want 10", top); end
        vectors++; if ({empty, full} !== 2'b00) begin miscompares++; $display("FAIL push3_flags got %b want 00", {empty, full}); end
        cyc(0, 1, 2'b00, 0, 0, 0, 0);
        vectors++; if (count !== 2 || top !== 2'b11) begin miscompares++; $display("FAIL pop_top got count=%0d top=%b want 2/11", count, top); end
    endtask

    task automatic test_overflow_clr();
        cyc(0, 0, 2'b00, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, DATA_W'(i + 1), 0, 0, 0, 0);
        cyc(1, 0, 2'b00, 0, 0, 0, 0);
        vectors++; if ({full, count} !== {1'b1, 3'd4}) begin miscompares++; $display("FAIL ovf_full got full=%b count=%0d want 1/4", full, count); end
        vectors++; if (ovf_err !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b want 1", ovf_err); end
        vectors++; if (top !== 2'b00) begin miscompares++; $display("FAIL ovf_top got %b want 00", top); end
        cyc(0, 0, 2'b00, 1, 0, 0, 0);
        vectors++; if ({count, ovf_err, empty} !== {3'd0, 1'b0, 1'b1}) begin miscompares++; $display("FAIL clr_state got count=%0d ovf=%b empty=%b want 0/0/1", count, ovf_err, empty); end
    endtask

    task automatic test_underflow_replace();
        cyc(0, 1, 2'b00, 0, 0, 0, 0);
        vectors++; if ({unf_err, count} !== {1'b1, 3'd0}) begin miscompares++; $display("FAIL unf got unf=%b count=%0d want 1/0", unf_err, count); end
        cyc(1, 1, 2'b10, 0, 0, 0, 0);
        vectors++; if ({count, top} !== {3'd1, 2'b10}) begin miscompares++; $display("FAIL pushpop_empty got count=%0d top=%b want 1/10", count, top); end
        cyc(0, 0, 2'b00, 1, 0, 0, 0);
        cyc(1, 0, 2'b01, 0, 0, 0, 0);
        cyc(1, 0, 2'b11, 0, 0, 0, 0);
        cyc(1, 1, 2'b00, 0, 0, 0, 0);
        vectors++; if ({count, top} !== {3'd2, 2'b00}) begin miscompares++; $display("FAIL replace_top got count=%0d top=%b want 2/00", count, top); end
        cyc(0, 1, 2'b00, 0, 0, 0, 0);
        vectors++; if (top !== 2'b01) begin miscompares++; $display("FAIL replace_mem0 got %b want 01", top); end
    endtask

    task automatic test_replay();
        logic [DATA_W-1:0] want [3];
        want[0] = 2'b01; want[1] = 2'b11; want[2] = 2'b10;
        cyc(0, 0, 2'b00, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, want[i], 0, 0, 0, 0);
        cyc(0, 0, 2'b00, 0, 1, 0, 0);
        vectors++; if ({replay_valid, replay_done} !== 2'b00) begin miscompares++; $display("FAIL replay_start got v/d=%b want 00", {replay_valid, replay_done}); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 2'b00, 0, 0, 1, 0);
            vectors++; if ({replay_valid, replay_data} !== {1'b1, want[i]}) begin miscompares++; $display("FAIL replay_entry%0d got v=%b d=%b want 1/%b", i, replay_valid, replay_data, want[i]); end
            vectors++; if (replay_done !== (i == 2)) begin miscompares++; $display("FAIL replay_done%0d got %b want %b", i, replay_done, i == 2); end
            if (i == 0) begin
                cyc(0, 0, 2'b00, 0, 0, 0, 0);
                vectors++; if (replay_valid !== 1'b0) begin miscompares++; $display("FAIL valid_strobe got %b want 0", replay_valid); end
            end
        end
        cyc(0, 0, 2'b00, 0, 0, 1, 0);
        vectors++; if ({replay_valid, replay_done} !== 2'b01) begin miscompares++; $display("FAIL next_in_done got v/d=%b want 01", {replay_valid, replay_done}); end
        vectors++; if ({count, top} !== {3'd3, 2'b10}) begin miscompares++; $display("FAIL replay_nondestr got count=%0d top=%b want 3/10", count, top); end
        cyc(1, 0, 2'b11, 0, 0, 0, 0);
        vectors++; if ({mode_err, count} !== {1'b1, 3'd3}) begin miscompares++; $display("FAIL push_in_done got merr=%b count=%0d want 1/3", mode_err, count); end
        cyc(0, 0, 2'b00, 0, 0, 0, 1);
    endtask

    task automatic test_rst_mid_replay();
        cyc(0, 0, 2'b00, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, DATA_W'(3 - i), 0, 0, 0, 0);
        cyc(0, 0, 2'b00, 0, 1, 0, 0);
        cyc(0, 0, 2'b00, 0, 0, 1, 0);
        vectors++; if (replay_valid !== 1'b1) begin miscompares++; $display("FAIL pre_rst_valid got %b want 1", replay_valid); end
        #3 rst = 0;
        model_reset();
        #1;
        vectors++; if ({count, replay_valid, replay_done, replay_data, top} !== 9'b0) begin miscompares++; $display("FAIL async_rst got %b want 0", {count, replay_valid, replay_done, replay_data, top}); end
        vectors++; if ({empty, ovf_err, unf_err, mode_err} !== 4'b1000) begin miscompares++; $display("FAIL async_rst_flags got %b want 1000", {empty, ovf_err, unf_err, mode_err}); end
        @(posedge cl); #1 rst = 1;
        cyc(0, 0, 2'b00, 0, 1, 0, 0);
        vectors++; if ({replay_done, replay_valid, count} !== {1'b1, 1'b0, 3'd0}) begin miscompares++; $display("FAIL start_empty got d=%b v=%b count=%0d want 1/0/0", replay_done, replay_valid, count); end
        cyc(0, 0, 2'b00, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] m_top;
        cyc(0, 0, 2'b00, 1, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 30, DATA_W'($urandom),
                $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
                $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 5);
            m_top = (stk.size() > 0) ? stk[stk.size()-1] : '0;
            vectors++; if (count !== CNT_W'(stk.size())) begin miscompares++; $display("FAIL rnd_count@%0d got %0d want %0d", n, count, stk.size()); end
            vectors++; if (top !== m_top) begin miscompares++; $display("FAIL rnd_top@%0d got %b want %b", n, top, m_top); end
            vectors++; if (replay_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid@%0d got %b want %b", n, replay_valid, m_valid); end
            vectors++; if (replay_data !== m_data) begin miscompares++; $display("FAIL rnd_data@%0d got %b want %b", n, replay_data, m_data); end
            vectors++; if (replay_done !== (m_mode == 2)) begin miscompares++; $display("FAIL rnd_done@%0d got %b want %b", n, replay_done, m_mode == 2); end
            vectors++; if ({full, empty} !== {stk.size() == DEPTH, stk.size() == 0}) begin miscompares++; $display("FAIL rnd_full_empty@%0d got %b", n, {full, empty}); end
            vectors++; if ({ovf_err, unf_err, mode_err} !== {m_ovf, m_unf, m_merr}) begin miscompares++; $display("FAIL rnd_errs@%0d got %b want %b", n, {ovf_err, unf_err, mode_err}, {m_ovf, m_unf, m_merr}); end
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow_clr();
        test_underflow_replace();
        test_replay();
        test_rst_mid_replay();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/path_buffer.md
Name: path_buffer

Overview:
- Parametrised direction-history store for the maze walker.
- Operates as a LIFO during search: push each move, pop on backtrack.
- After search, replays the stored path non-destructively in oldest-first order for the show-move phase.
- Sits between the walker controller and the position registers. Replaces the fixed 256×2 stack and adds full, overflow and underflow detection, same-cycle push+pop, and a proper replay FSM.

Parameters:
- DATA_W, 2, bits per stored move (direction code).
- DEPTH, 256, maximum stored entries; need not be a power of two.
- CNT_W, $clog2(DEPTH+1), width of count and pointers.

Ports:
- cl  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately).
- clr  in  1  synchronous clear: count, pointers and error flags to 0, FSM to IDLE.
- push  in  1  write din on top of stack.
- pop  in  1  discard top entry.
- din  in  DATA_W  move to push.
- top  out  DATA_W  combinational mem[count-1]; 0 when empty.
- count  out  CNT_W  entries held.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- replay_start  in  1  enter replay from oldest entry.
- replay_next  in  1  emit next replay entry.
- replay_stop  in  1  leave replay and return to stack mode.
- replay_data  out  DATA_W  registered replay entry.
- replay_valid  out  1  one-cycle strobe qualifying replay_data.
- replay_done  out  1  high in DONE state.
- ovf_err  out  1  sticky: push while full.
- unf_err  out  1  sticky: pop while empty.
- mode_err  out  1  sticky: push or pop outside IDLE.

Behaviour:
- Reset (rst=0, async) drives all of the following to 0:
  - count, rd_ptr, replay_data, replay_valid, replay_done, all error flags;
  - FSM to IDLE.
  - Memory contents are not reset.
- Priority per cycle: clr > replay_start/replay_next/replay_stop (per state) > push/pop.
- FSM states: IDLE (stack mode), REPLAY, DONE.
- IDLE, push only:
  - if not full: mem[count] <= din, count+1;
  - if full: ignored, ovf_err <= 1.
- IDLE, pop only:
  - if not empty: count-1;
  - if empty: ignored, unf_err <= 1.
- IDLE, push and pop together:
  - if not empty: replace top, i.e. mem[count-1] <= din, count unchanged;
  - if empty: behaves as push, no underflow.
- top is combinational and reflects a write on the cycle after it.
- IDLE, replay_start:
  - rd_ptr <= 0;
  - go to REPLAY if count>0, else go to DONE;
  - any push/pop in the same cycle is ignored and sets mode_err.
- REPLAY, replay_next:
  - replay_data <= mem[rd_ptr], replay_valid <= 1 for exactly one cycle, rd_ptr+1.
  - Latency is one cycle from replay_next to replay_valid.
  - When rd_ptr+1 == count, go to DONE in the same edge that asserts replay_valid for the last entry.
- REPLAY, replay_stop:
  - go to IDLE with rd_ptr <= 0; stack contents are untouched.
- DONE:
  - replay_done=1;
  - replay_next is ignored and produces no valid;
  - replay_start restarts replay from index 0;
  - replay_stop returns to IDLE.
- replay_valid is 0 in every cycle not caused by an accepted replay_next.
- Push or pop in REPLAY or DONE: ignored, mode_err <= 1.
- clr in any state: count, rd_ptr, error flags and replay_valid to 0; FSM to IDLE; replay_data holds its value.
- Error flags are sticky until clr or rst.
- count never wraps: it saturates logically at 0 and DEPTH via the guards above.
- Asserting rst mid-replay aborts immediately; after release the FSM is in IDLE and count=0.

Decomposition:
- Shared package path_pkg holds:
  - direction codes DIR_UP=2'b00, DIR_RIGHT=2'b01, DIR_LEFT=2'b10, DIR_DOWN=2'b11;
  - FSM state encoding PB_IDLE, PB_REPLAY, PB_DONE.
- One sub-module, path_buffer_ram: DEPTH×DATA_W, one synchronous write port, two combinational read ports (top and replay), no reset.

Test Plan (DEPTH=4):
- Push 01,11,10 -> count=3, top=10, empty=0, full=0. Then pop -> count=2, top=11.
- Push 4 entries, push again with din=00 -> full=1, count=4, ovf_err=1, top unchanged. Then clr -> count=0, ovf_err=0, empty=1.
- Pop on empty -> unf_err=1, count=0. Push+pop on empty with din=10 -> count=1, top=10.
- Holding 01,11, push+pop with din=00 -> count=2, top=00, mem[0]=01.
- Push 01,11,10, replay_start, then replay_next ×4 -> replay_data 01,11,10 each with one-cycle valid. replay_done rises with the third valid; the fourth next gives no valid; count is still 3 and top=10. push in DONE -> mode_err=1.
- Mid-replay (after first valid) drive rst=0 -> all outputs 0 at once, FSM IDLE. After release, empty=1 and replay_start -> DONE with no valid.
